// File: rtl/reg_scoreboard.sv
// reg_scoreboard: GPR scoreboard and issue gate for the ID stage.
//   Tracks in-flight writers per GPR (r1..r31) and which destinations still
//   wait on load data. Drives stall (readygo = ~stall) and busy hints for
//   the ID forwarding muxes.
// Ports:
//   clk, rst           clock, async active-high reset
//   src1_*/src2_*      ID source addresses and use strobes
//   issue_*            ID->EX transfer; issue_tag is this instruction's tag
//   load_done[_tag]    MEM load data available for the given tag
//   wb_*               WB retirement
//   clear_all          pipeline-wide cancel (sync, highest priority)
//   stall, src*_busy   combinational from current state and ID inputs
//   inflight           total in-flight writers
//   perf_stall_cnt     stall cycle counter, present when SB_PERF_EN is defined
// Optional macro: SB_PERF_EN

// One tracked register: writer count, pending-load flag and the load's tag.
module sb_entry #(
  parameter int CNT_W = 2,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  input  logic             is_load,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             ld_done,
  input  logic [TAG_W-1:0] ld_done_tag,
  output logic [CNT_W-1:0] cnt,
  output logic             ld_pend
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_pend_q, ld_pend_d;
  logic [TAG_W-1:0] ld_tag_q, ld_tag_d;

  always_comb begin
    cnt_d     = cnt_q;
    ld_pend_d = ld_pend_q;
    ld_tag_d  = ld_tag_q;
    if (clear) begin
      cnt_d     = '0;
      ld_pend_d = 1'b0;
      ld_tag_d  = '0;
    end else begin
      // issue and WB together cancel; saturate/underflow hold the count
      if (inc && !dec && cnt_q != CNT_MAX)   cnt_d = cnt_q + 1'b1;
      else if (dec && !inc && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
      // tag match guards against a stale load whose entry was overwritten
      if (ld_done && ld_pend_q && ld_tag_q == ld_done_tag) ld_pend_d = 1'b0;
      // youngest writer decides the pending state; overrides a same-cycle done
      if (inc) begin
        ld_pend_d = is_load;
        if (is_load) ld_tag_d = tag_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ld_pend_q <= 1'b0;
      ld_tag_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ld_pend_q <= ld_pend_d;
      ld_tag_q  <= ld_tag_d;
    end
  end

  assign cnt     = cnt_q;
  assign ld_pend = ld_pend_q;
endmodule

module reg_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int TAG_W        = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1_addr,
  input  logic             src1_use,
  input  logic [4:0]       src2_addr,
  input  logic             src2_use,
  input  logic             issue_fire,
  input  logic             issue_we,
  input  logic [4:0]       issue_dest,
  input  logic             issue_is_load,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             load_done,
  input  logic [TAG_W-1:0] load_done_tag,
  input  logic             wb_fire,
  input  logic             wb_we,
  input  logic [4:0]       wb_dest,
  input  logic             clear_all,
  output logic             stall,
  output logic             src1_busy,
  output logic             src2_busy,
  output logic [2:0]       inflight,
  output logic [31:0]      perf_stall_cnt
);
  localparam int NREG  = 32;
  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            ld_pend;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [SUM_W-1:0]           sum;

  // r0 is hardwired zero: never busy, never pending
  assign cnt[0]     = '0;
  assign ld_pend[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(.CNT_W(CNT_W), .TAG_W(TAG_W)) u_ent (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear_all),
      .inc         (issue_fire && issue_we && issue_dest == 5'(r)),
      .dec         (wb_fire && wb_we && wb_dest == 5'(r)),
      .is_load     (issue_is_load),
      .tag_in      (tag_q),
      .ld_done     (load_done),
      .ld_done_tag (load_done_tag),
      .cnt         (cnt[r]),
      .ld_pend     (ld_pend[r])
    );
  end

  // free-running tag; deliberately survives clear_all so tags stay unique
  always_comb tag_d = issue_fire ? tag_q + 1'b1 : tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < NREG; r++) sum = sum + SUM_W'(cnt[r]);
  end

  assign issue_tag = tag_q;
  assign inflight  = sum[2:0];
  assign src1_busy = src1_use && cnt[src1_addr] != '0;
  assign src2_busy = src2_use && cnt[src2_addr] != '0;
  assign stall     = (src1_use && ld_pend[src1_addr]) ||
                     (src2_use && ld_pend[src2_addr]) ||
                     (issue_we && cnt[issue_dest] == CNT_MAX) ||
                     (issue_we && sum == SUM_W'(MAX_INFLIGHT));

`ifdef SB_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb perf_d = (stall && perf_q != 32'hFFFF_FFFF) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end
  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

  // retiring a writer that was never counted means upstream bookkeeping broke
  a_wb_underflow: assert property (@(posedge clk) disable iff (rst)
    !(wb_fire && wb_we && wb_dest != 5'd0 && !clear_all && cnt[wb_dest] == '0));
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  logic        clk, rst;
  logic [4:0]  src1_addr, src2_addr, issue_dest, wb_dest;
  logic        src1_use, src2_use, issue_fire, issue_we, issue_is_load;
  logic        load_done, wb_fire, wb_we, clear_all;
  logic [2:0]  load_done_tag, issue_tag, inflight;
  logic        stall, src1_busy, src2_busy;
  logic [31:0] perf_stall_cnt;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .src1_addr(src1_addr), .src1_use(src1_use),
    .src2_addr(src2_addr), .src2_use(src2_use),
    .issue_fire(issue_fire), .issue_we(issue_we), .issue_dest(issue_dest),
    .issue_is_load(issue_is_load), .issue_tag(issue_tag),
    .load_done(load_done), .load_done_tag(load_done_tag),
    .wb_fire(wb_fire), .wb_we(wb_we), .wb_dest(wb_dest),
    .clear_all(clear_all),
    .stall(stall), .src1_busy(src1_busy), .src2_busy(src2_busy),
    .inflight(inflight), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] s1a; logic s1u; logic [4:0] s2a; logic s2u;
    logic fire; logic we; logic [4:0] dest; logic ld;
    logic ldn; logic [2:0] ldt; logic wbf; logic [4:0] wbd; logic clr;
    logic st; logic b1; logic b2; logic [2:0] inf; logic [2:0] tg;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];
  vec_t exp_q[$];
  int   applied = 0;
  int   miscompares = 0;
  int   perf_exp = 0;

  function automatic vec_t V(
    input logic [4:0] s1a, input logic s1u, input logic [4:0] s2a, input logic s2u,
    input logic fire, input logic we, input logic [4:0] dest, input logic ld,
    input logic ldn, input logic [2:0] ldt, input logic wbf, input logic [4:0] wbd,
    input logic clr, input logic st, input logic b1, input logic b2,
    input logic [2:0] inf, input logic [2:0] tg);
    vec_t v;
    v.s1a = s1a; v.s1u = s1u; v.s2a = s2a; v.s2u = s2u;
    v.fire = fire; v.we = we; v.dest = dest; v.ld = ld;
    v.ldn = ldn; v.ldt = ldt; v.wbf = wbf; v.wbd = wbd; v.clr = clr;
    v.st = st; v.b1 = b1; v.b2 = b2; v.inf = inf; v.tg = tg;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    src1_addr = v.s1a; src1_use = v.s1u; src2_addr = v.s2a; src2_use = v.s2u;
    issue_fire = v.fire; issue_we = v.we; issue_dest = v.dest; issue_is_load = v.ld;
    load_done = v.ldn; load_done_tag = v.ldt;
    wb_fire = v.wbf; wb_we = v.wbf; wb_dest = v.wbd; clear_all = v.clr;
  endtask

  // drive at negedge, sample 1ns later, state advances at the following posedge
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    chk("stall", idx, 32'(stall), 32'(e.st));
    chk("src1_busy", idx, 32'(src1_busy), 32'(e.b1));
    chk("src2_busy", idx, 32'(src2_busy), 32'(e.b2));
    chk("inflight", idx, 32'(inflight), 32'(e.inf));
    chk("issue_tag", idx, 32'(issue_tag), 32'(e.tg));
    if (issue_fire && stall) begin
      miscompares++;
      $display("FAIL fire_while_stall vec %0d: got fire=1 stall=1 required stall=0", idx);
    end
    if (e.st) perf_exp++;
  endtask

  initial begin
    vec_t z;
    rst = 1'b1;
    z = V(0,0,0,0, 0,0,0,0, 0,0, 0,0, 0, 0,0,0,0,0);
    drive(z);
    //        s1a u s2a u  f we d  ld ldn t wb wd clr st b1 b2 inf tg
    // load-use
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0,0));
    vecs.push_back(V(0,0, 0,0, 1,1, 4,1, 0,0, 0,0, 0, 0,0,0,0,0));
    vecs.push_back(V(4,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 1,1,0,1,1));
    vecs.push_back(V(4,1, 0,0, 0,0, 0,0, 1,0, 0,0, 0, 1,1,0,1,1));
    vecs.push_back(V(4,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,1,0,1,1));
    vecs.push_back(V(4,1, 0,0, 0,0, 0,0, 0,0, 1,4, 0, 0,1,0,1,1));
    vecs.push_back(V(4,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0,1));
    // ALU forward
    vecs.push_back(V(0,0, 0,0, 1,1, 5,0, 0,0, 0,0, 0, 0,0,0,0,1));
    vecs.push_back(V(0,0, 5,1, 0,0, 0,0, 0,0, 0,0, 0, 0,0,1,1,2));
    vecs.push_back(V(0,0, 5,1, 0,0, 0,0, 0,0, 1,5, 0, 0,0,1,1,2));
    vecs.push_back(V(0,0, 5,1, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0,2));
    // stale tag
    vecs.push_back(V(0,0, 0,0, 1,1, 6,1, 0,0, 0,0, 0, 0,0,0,0,2));
    vecs.push_back(V(6,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 1,1,0,1,3));
    vecs.push_back(V(0,0, 0,0, 1,1, 6,0, 0,0, 0,0, 0, 0,0,0,1,3));
    vecs.push_back(V(6,1, 0,0, 0,0, 0,0, 1,2, 0,0, 0, 0,1,0,2,4));
    vecs.push_back(V(6,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,1,0,2,4));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 1,6, 0, 0,0,0,2,4));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 1,6, 0, 0,0,0,1,4));
    // saturation on r7
    vecs.push_back(V(0,0, 0,0, 1,1, 7,0, 0,0, 0,0, 0, 0,0,0,0,4));
    vecs.push_back(V(0,0, 0,0, 1,1, 7,0, 0,0, 0,0, 0, 0,0,0,1,5));
    vecs.push_back(V(0,0, 0,0, 1,1, 7,0, 0,0, 0,0, 0, 0,0,0,2,6));
    vecs.push_back(V(0,0, 0,0, 0,1, 7,0, 0,0, 0,0, 0, 1,0,0,3,7));
    vecs.push_back(V(0,0, 0,0, 0,1, 7,0, 0,0, 1,7, 0, 1,0,0,3,7));
    vecs.push_back(V(0,0, 0,0, 0,1, 7,0, 0,0, 0,0, 0, 0,0,0,2,7));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 1,7, 0, 0,0,0,2,7));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 1,7, 0, 0,0,0,1,7));
    // same-cycle issue+WB on r8, tag wraps 7->0
    vecs.push_back(V(0,0, 0,0, 1,1, 8,0, 0,0, 0,0, 0, 0,0,0,0,7));
    vecs.push_back(V(0,0, 0,0, 1,1, 8,0, 0,0, 1,8, 0, 0,0,0,1,0));
    vecs.push_back(V(8,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,1,0,1,1));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 1,8, 0, 0,0,0,1,1));
    vecs.push_back(V(8,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0,1));
    // r0 never tracked
    vecs.push_back(V(0,0, 0,0, 1,1, 0,1, 0,0, 0,0, 0, 0,0,0,0,1));
    vecs.push_back(V(0,1, 0,1, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0,2));
    // fill to MAX_INFLIGHT, then clear_all
    vecs.push_back(V(0,0, 0,0, 1,1, 9,0, 0,0, 0,0, 0, 0,0,0,0,2));
    vecs.push_back(V(0,0, 0,0, 1,1,10,0, 0,0, 0,0, 0, 0,0,0,1,3));
    vecs.push_back(V(0,0, 0,0, 1,1,11,0, 0,0, 0,0, 0, 0,0,0,2,4));
    vecs.push_back(V(0,0, 0,0, 1,1,12,1, 0,0, 0,0, 0, 0,0,0,3,5));
    vecs.push_back(V(0,0, 0,0, 0,1,13,0, 0,0, 0,0, 0, 1,0,0,4,6));
    vecs.push_back(V(12,1,0,0, 0,0, 0,0, 0,0, 1,9, 1, 1,1,0,4,6));
    vecs.push_back(V(12,1,9,1, 0,1,13,0, 0,0, 0,0, 0, 0,0,0,0,6));
    vecs.push_back(V(0,0, 0,0, 1,1,13,1, 0,0, 0,0, 0, 0,0,0,0,6));
    vecs.push_back(V(13,1,0,0, 0,0, 0,0, 0,0, 0,0, 0, 1,1,0,1,7));

    // issue-load and load_done for the same register in one cycle
    post.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0,0));
    post.push_back(V(0,0, 0,0, 1,1,14,1, 0,0, 0,0, 0, 0,0,0,0,0));
    post.push_back(V(0,0, 0,0, 1,1,14,1, 1,0, 0,0, 0, 0,0,0,1,1));
    post.push_back(V(14,1,0,0, 0,0, 0,0, 1,0, 0,0, 0, 1,1,0,2,2));
    post.push_back(V(14,1,0,0, 0,0, 0,0, 1,1, 0,0, 0, 1,1,0,2,2));
    post.push_back(V(14,1,0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,1,0,2,2));
    post.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 1,14,0, 0,0,0,2,2));
    post.push_back(V(0,0, 0,0, 0,0, 0,0, 0,0, 1,14,0, 0,0,0,1,2));
    post.push_back(V(0,0,14,1, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0,2));

    #12;
    chk("rst_stall", -1, 32'(stall), 32'd0);
    chk("rst_inflight", -1, 32'(inflight), 32'd0);
    chk("rst_tag", -1, 32'(issue_tag), 32'd0);
    chk("rst_perf", -1, perf_stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    perf_exp = 0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // async reset while stalled on r13's pending load
    @(negedge clk);
    drive(vecs[vecs.size()-1]);
    #1;
    chk("pre_rst_stall", 100, 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_stall", 101, 32'(stall), 32'd0);
    chk("async_rst_busy", 101, 32'(src1_busy), 32'd0);
    chk("async_rst_inflight", 101, 32'(inflight), 32'd0);
    chk("async_rst_tag", 101, 32'(issue_tag), 32'd0);
    @(negedge clk);
    drive(z);
    rst = 1'b0;
    perf_exp = 0;

    for (int i = 0; i < post.size(); i++) step(post[i], 200 + i);

    @(negedge clk);
    drive(z);
`ifdef SB_PERF_EN
    chk("perf_stall_cnt", 300, perf_stall_cnt, 32'(perf_exp));
`else
    chk("perf_stall_cnt", 300, perf_stall_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
